// File: rtl/udp_payload_buffer.sv
// udp_payload_buffer -- two-bank (ping-pong) store-and-forward buffer for UDP payload bytes.
//   Latency: a packet is offered (pkt_valid) the cycle after its last byte is written; rd_data
//   is registered and appears one cycle after rd_en.
//   Backpressure: wr_ready drops while the write bank is still FULL/READING; it returns the
//   cycle after that bank's rd_last. rd_en with no packet available is ignored.
//
// Ports:
//   GMII_GTXCLK, rst_n        - clock, synchronous active-low reset
//   wr_valid/wr_data/wr_last  - byte-wide writer input, accepted when wr_valid & wr_ready
//   wr_ready                  - writer may present a byte this cycle
//   pkt_valid/pkt_len         - committed packet waiting to be read, and its byte count
//   rd_en                     - sender pulls the next byte
//   rd_data/rd_last           - registered read byte, rd_last flags the final byte
//   err_oversize              - one-cycle pulse when a packet longer than MAX_SIZE is dropped
//
// Build option: define UDP_PAYLOAD_PAD_EN to pad packets shorter than 18 bytes with 8'h00
// up to 18 bytes (reported pkt_len and read stream both padded).

module udp_payload_buffer #(
  parameter int MAX_SIZE = 1472,
  parameter int ADDR_W   = 11
) (
  input  logic        GMII_GTXCLK,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        pkt_valid,
  output logic [10:0] pkt_len,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  output logic        err_oversize
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [10:0] MAX_LEN = 11'(MAX_SIZE);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FULL    = 2'd1,
    B_READING = 2'd2
  } bank_st_t;

  typedef enum logic {
    W_FILL = 1'b0,
    W_DROP = 1'b1
  } wr_st_t;

  // Both banks share one array; the top address bit selects the bank.
  logic [7:0]  r_mem [0:2*DEPTH-1];

  bank_st_t    r_bank_st  [0:1];
  logic [10:0] r_bank_len [0:1];
  logic        r_wr_bank;
  logic        r_rd_bank;
  logic [10:0] r_wr_cnt;
  wr_st_t      r_wr_st;
  wr_st_t      w_wr_st_nxt;
  logic [10:0] r_rd_addr;
  logic [7:0]  r_rd_data;
  logic        r_rd_last;
  logic        r_err;

  // ---------------------------------------------------------------------------
  // Writer decode
  // ---------------------------------------------------------------------------
  logic w_wr_bank_free;
  logic w_wr_acc;
  logic w_at_max;
  logic w_store;
  logic w_commit;
  logic w_drop_end;
  logic w_enter_drop;

  // A bank released by the reader this cycle (rd_last high, read pointer already moved on)
  // is held off for one more cycle so wr_ready rises the cycle after rd_last. Only a writer
  // that was already blocked on that bank can see this mask.
  assign w_wr_bank_free = (r_bank_st[r_wr_bank] == B_EMPTY) &&
                          !(r_rd_last && (r_wr_bank != r_rd_bank));

  assign w_wr_acc     = wr_valid && wr_ready;
  assign w_at_max     = (r_wr_cnt == MAX_LEN);
  assign w_store      = w_wr_acc && (r_wr_st == W_FILL) && !w_at_max;
  assign w_commit     = w_store && wr_last;
  // Oversize packet ends either on the (MAX_SIZE+1)th byte itself or later in W_DROP.
  assign w_drop_end   = w_wr_acc && wr_last && ((r_wr_st == W_DROP) || w_at_max);
  assign w_enter_drop = w_wr_acc && (r_wr_st == W_FILL) && w_at_max && !wr_last;

  // Writer FSM: state register
  always_ff @(posedge GMII_GTXCLK) begin
    if (!rst_n) begin
      r_wr_st <= W_FILL;
    end else begin
      r_wr_st <= w_wr_st_nxt;
    end
  end

  // Writer FSM: next state
  always_comb begin
    w_wr_st_nxt = r_wr_st;
    case (r_wr_st)
      W_FILL:  if (w_enter_drop)         w_wr_st_nxt = W_DROP;
      W_DROP:  if (w_wr_acc && wr_last)  w_wr_st_nxt = W_FILL;
      default:                           w_wr_st_nxt = W_FILL;
    endcase
  end

  // Writer FSM: outputs (held low throughout reset)
  always_comb begin
    wr_ready = 1'b0;
    if (rst_n) begin
      case (r_wr_st)
        W_FILL:  wr_ready = w_wr_bank_free;
        W_DROP:  wr_ready = 1'b1;
        default: wr_ready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Reader decode
  // ---------------------------------------------------------------------------
  bank_st_t    w_rd_st;
  logic        w_rd_start;
  logic        w_rd_fire;
  logic [10:0] w_rd_addr;
  logic [10:0] w_rd_len;
  logic        w_rd_is_last;
  logic [7:0]  w_mem_q;
  logic [7:0]  w_rd_byte;

  assign w_rd_st      = r_bank_st[r_rd_bank];
  assign w_rd_start   = rd_en && (w_rd_st == B_FULL);
  assign w_rd_fire    = rd_en && (w_rd_st != B_EMPTY);
  assign w_rd_addr    = w_rd_start ? 11'd0 : r_rd_addr;
  assign w_mem_q      = r_mem[{r_rd_bank, ADDR_W'(w_rd_addr)}];
  assign w_rd_is_last = (w_rd_addr == (w_rd_len - 11'd1));

`ifdef UDP_PAYLOAD_PAD_EN
  // Short packets are stretched to 18 bytes; the tail reads as zero rather than stale RAM.
  localparam logic [10:0] PAD_LEN = 11'd18;
  assign w_rd_len  = (r_bank_len[r_rd_bank] < PAD_LEN) ? PAD_LEN : r_bank_len[r_rd_bank];
  assign w_rd_byte = (w_rd_addr < r_bank_len[r_rd_bank]) ? w_mem_q : 8'h00;
`else
  assign w_rd_len  = r_bank_len[r_rd_bank];
  assign w_rd_byte = w_mem_q;
`endif

  assign pkt_valid    = (w_rd_st == B_FULL);
  assign pkt_len      = pkt_valid ? w_rd_len : 11'd0;
  assign rd_data      = r_rd_data;
  assign rd_last      = r_rd_last;
  assign err_oversize = r_err;

  // ---------------------------------------------------------------------------
  // Payload RAM (contents survive reset; bank state decides what is valid)
  // ---------------------------------------------------------------------------
  always_ff @(posedge GMII_GTXCLK) begin
    if (w_store) begin
      r_mem[{r_wr_bank, ADDR_W'(r_wr_cnt)}] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank bookkeeping and read datapath. Writer only moves an EMPTY bank to FULL and the
  // reader only touches FULL/READING banks, so the two never update the same bank at once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge GMII_GTXCLK) begin
    if (!rst_n) begin
      r_bank_st[0]  <= B_EMPTY;
      r_bank_st[1]  <= B_EMPTY;
      r_bank_len[0] <= 11'd0;
      r_bank_len[1] <= 11'd0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_cnt      <= 11'd0;
      r_rd_addr     <= 11'd0;
      r_rd_data     <= 8'h00;
      r_rd_last     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_drop_end;

      if (w_commit) begin
        r_bank_st[r_wr_bank]  <= B_FULL;
        r_bank_len[r_wr_bank] <= r_wr_cnt + 11'd1;
        r_wr_cnt              <= 11'd0;
        r_wr_bank             <= !r_wr_bank;
      end else if (w_store) begin
        r_wr_cnt <= r_wr_cnt + 11'd1;
      end else if (w_drop_end) begin
        r_wr_cnt <= 11'd0;
      end

      r_rd_last <= 1'b0;
      if (w_rd_fire) begin
        r_rd_data <= w_rd_byte;
        r_rd_addr <= w_rd_addr + 11'd1;
        if (w_rd_is_last) begin
          r_bank_st[r_rd_bank] <= B_EMPTY;
          r_rd_bank            <= !r_rd_bank;
          r_rd_last            <= 1'b1;
        end else if (w_rd_start) begin
          r_bank_st[r_rd_bank] <= B_READING;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_buffer.sv
module tb_udp_payload_buffer;

  localparam int MAX_SIZE = 1472;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        pkt_valid;
  logic [10:0] pkt_len;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        err_oversize;

  udp_payload_buffer #(.MAX_SIZE(MAX_SIZE), .ADDR_W(11)) dut (
    .GMII_GTXCLK  (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .wr_ready     (wr_ready),
    .pkt_valid    (pkt_valid),
    .pkt_len      (pkt_len),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .err_oversize (err_oversize)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         last;
  } exp_byte_t;

  int        checks;
  int        errors;
  exp_byte_t exp_bytes[$];
  int        exp_len[$];
  int        exp_err;
  bit        rd_dummy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: a packet of len bytes either appears later, in write order, as the same
  // bytes (zero-padded to 18 when padding is built in), or is dropped with one error pulse.
  task automatic send_pkt(input int len, input bit rnd, input logic [7:0] base, input int gap_pct);
    logic [7:0] b[$];
    int  plen;
    int  t;
    bit  ok;
    for (int i = 0; i < len; i++) b.push_back(rnd ? 8'($urandom) : 8'(int'(base) + i));
    if (len > MAX_SIZE) begin
      exp_err++;
    end else begin
      plen = len;
`ifdef UDP_PAYLOAD_PAD_EN
      if (plen < 18) plen = 18;
`endif
      exp_len.push_back(plen);
      for (int i = 0; i < plen; i++)
        exp_bytes.push_back('{d: (i < len) ? b[i] : 8'h00, last: (i == plen - 1)});
    end
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        wr_valid = 1'b0;
        @(posedge clk); #1;
      end
      wr_valid = 1'b1;
      wr_data  = b[i];
      wr_last  = (i == len - 1);
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 5000) begin
        @(negedge clk);
        ok = wr_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL wr_ready_timeout actual=0 required=1");
        break;
      end
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // mode 0: continuous rd_en, 1: rd_en every other cycle, 2: random gaps
  task automatic read_pkts(input int n, input int mode, input int max_reads);
    int t;
    int len;
    bit seen;
    for (int p = 0; p < n; p++) begin
      seen = 1'b0;
      t    = 0;
      while (!seen && t < 20000) begin
        @(negedge clk);
        seen = pkt_valid;
        t++;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL pkt_valid_timeout actual=0 required=1");
        return;
      end
      len = int'(pkt_len);
      @(posedge clk); #1;
      for (int k = 0; k < len && k < max_reads; k++) begin
        rd_en = 1'b1;
        @(posedge clk); #1;
        if (mode == 1 || (mode == 2 && $urandom_range(99, 0) < 30)) begin
          rd_en = 1'b0;
          @(posedge clk); #1;
        end
      end
      rd_en = 1'b0;
    end
  endtask

  // Monitor: every rd_en issued by the reader yields exactly one byte on the following cycle;
  // all other cycles must hold rd_data with rd_last low.
  initial begin
    bit         prev_issue;
    bit         in_pkt;
    logic [7:0] last_d;
    exp_byte_t  e;
    prev_issue = 1'b0;
    in_pkt     = 1'b0;
    last_d     = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_issue = 1'b0;
        in_pkt     = 1'b0;
        last_d     = 8'h00;
        continue;
      end
      if (prev_issue) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", rd_data);
        end else begin
          e = exp_bytes.pop_front();
          check("rd_data", rd_data, e.d);
          check("rd_last", rd_last, e.last);
          if (e.last) in_pkt = 1'b0;
        end
      end else begin
        check("rd_data_hold", rd_data, last_d);
        check("rd_last_idle", rd_last, 1'b0);
      end
      last_d     = rd_data;
      prev_issue = rd_en && !rd_dummy;
      if (prev_issue && !in_pkt) begin
        in_pkt = 1'b1;
        if (exp_len.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet actual=%0d required=none", pkt_len);
        end else begin
          check("pkt_len", pkt_len, exp_len.pop_front());
        end
      end
      if (err_oversize === 1'b1) begin
        checks++;
        if (exp_err > 0) exp_err--;
        else begin
          errors++;
          $display("FAIL err_oversize actual=1 required=0");
        end
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    exp_err  = 0;
    rd_dummy = 1'b0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    wr_last  = 1'b0;
    rd_en    = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_pkt_len", pkt_len, 11'd0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_err", err_oversize, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;

    // rd_en with nothing buffered is ignored
    rd_dummy = 1'b1;
    rd_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd_en    = 1'b0;
    rd_dummy = 1'b0;
    @(negedge clk);
    check("idle_pkt_valid", pkt_valid, 1'b0);
    @(posedge clk); #1;

    // 32-byte counting packet, continuous read
    send_pkt(32, 1'b0, 8'h00, 0);
    @(negedge clk);
    check("pkt32_valid", pkt_valid, 1'b1);
    read_pkts(1, 0, 100000);

    // Both banks fill, third writer stalls until the first packet is drained
    send_pkt(100, 1'b1, 8'h00, 0);
    send_pkt(100, 1'b1, 8'h00, 0);
    @(negedge clk);
    check("both_full_wr_ready", wr_ready, 1'b0);
    @(posedge clk); #1;
    fork
      send_pkt(100, 1'b1, 8'h00, 0);
      begin
        read_pkts(1, 0, 100000);
        @(negedge clk);
        check("release_rd_last", rd_last, 1'b1);
        check("release_wr_ready_same", wr_ready, 1'b0);
        @(negedge clk);
        check("release_wr_ready_next", wr_ready, 1'b1);
        @(posedge clk); #1;
      end
    join
    read_pkts(2, 0, 100000);

    // Oversize handling: MAX_SIZE+1 ending on the extra byte, a longer one via drop state,
    // then an exactly-MAX_SIZE packet and a normal one
    send_pkt(MAX_SIZE + 1, 1'b1, 8'h00, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("oversize_pkt_valid", pkt_valid, 1'b0);
    @(posedge clk); #1;
    send_pkt(MAX_SIZE + 28, 1'b1, 8'h00, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("drop_pkt_valid", pkt_valid, 1'b0);
    check("drop_wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;
    send_pkt(MAX_SIZE, 1'b1, 8'h00, 0);
    send_pkt(64, 1'b1, 8'h00, 0);
    read_pkts(2, 0, 100000);

    // Short packet (padded only when the option is built in)
    send_pkt(5, 1'b0, 8'hA1, 0);
    read_pkts(1, 0, 100000);

    // Read with rd_en toggling every cycle
    send_pkt(64, 1'b1, 8'h00, 0);
    read_pkts(1, 1, 100000);

    // Reset in the middle of reading a 200-byte packet
    send_pkt(200, 1'b1, 8'h00, 0);
    read_pkts(1, 0, 40);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_bytes.delete();
    exp_len.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_pkt_valid", pkt_valid, 1'b0);
    check("mid_rst_rd_last", rd_last, 1'b0);
    check("mid_rst_wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;
    send_pkt(64, 1'b1, 8'h00, 0);
    read_pkts(1, 0, 100000);

    // Random traffic with concurrent writer and reader, including oversize drops
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          if (i == 5 || i == 11) send_pkt(MAX_SIZE + 8, 1'b1, 8'h00, 25);
          else send_pkt(int'($urandom_range(160, 1)), 1'b1, 8'h00, 25);
        end
      end
      read_pkts(14, 2, 100000);
    join

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bytes_left", exp_bytes.size(), 0);
    check("pkts_left", exp_len.size(), 0);
    check("err_pulses_left", exp_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_payload_buffer.md
UDP_PAYLOAD_BUFFER -- requirements
Module: udp_payload_buffer

Interface
REQ-001 Parameter MAX_SIZE, default 1472: largest payload in bytes accepted per packet; legal range 32..2047.
REQ-002 Parameter ADDR_W, default 11: byte address width per bank; 2^ADDR_W SHALL be at least MAX_SIZE.
REQ-003 GMII_GTXCLK  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 wr_valid  input  1  writer presents a payload byte.
REQ-006 wr_data  input  8  payload byte.
REQ-007 wr_last  input  1  marks the final byte of the packet.
REQ-008 wr_ready  output  1  buffer accepts a byte this cycle.
REQ-009 pkt_valid  output  1  a complete packet is committed and not yet started.
REQ-010 pkt_len  output  11  byte count of the offered packet; valid while pkt_valid=1.
REQ-011 rd_en  input  1  sender requests the next byte.
REQ-012 rd_data  output  8  read byte, one cycle after rd_en.
REQ-013 rd_last  output  1  high with the final byte of the packet on rd_data.
REQ-014 err_oversize  output  1  one-cycle pulse when a packet is dropped for exceeding MAX_SIZE.

Function
REQ-015 The block SHALL hold two banks of 2^ADDR_W bytes (ping-pong); each bank is EMPTY, FULL or READING; packets SHALL be read in write order.
REQ-016 Writer FSM W_FILL/W_DROP: wr_ready=1 in W_FILL when the write bank is EMPTY; a byte is accepted when wr_valid & wr_ready.
REQ-017 Accepted byte with wr_last=0 and count<MAX_SIZE: store at count, count+1.
REQ-018 Accepted byte with wr_last=1 and count<MAX_SIZE: store; bank becomes FULL with length count+1; count clears; write bank toggles.
REQ-019 Accepted byte with count=MAX_SIZE (byte MAX_SIZE+1): go to W_DROP, discarding it, or, if wr_last=1, pulse err_oversize and remain in W_FILL.
REQ-020 W_DROP: wr_ready=1; bytes discarded up to and including wr_last; then pulse err_oversize, clear count, return to W_FILL on the same bank, still EMPTY.
REQ-021 pkt_valid=1 exactly while the read bank is FULL; pkt_len SHALL be that bank's stored length.
REQ-022 rd_en while pkt_valid=1 SHALL mark the bank READING, read address 0, and drop pkt_valid the next cycle.
REQ-023 rd_en while READING: read next address; rd_data is registered and updates exactly one cycle after rd_en.
REQ-024 rd_last=1 in the cycle rd_data carries byte length-1; that cycle the bank becomes EMPTY and the read bank toggles.
REQ-025 rd_en with no FULL or READING bank SHALL be ignored; rd_data holds its value and rd_last stays 0.
REQ-026 A gap in rd_en SHALL pause reading without loss; rd_data holds its last value.
REQ-027 Same-cycle commit by the writer and release by the reader on different banks SHALL both take effect.
REQ-028 Both banks FULL/READING: wr_ready=0 until a bank is released; wr_ready SHALL rise the cycle after rd_last.

Reset
REQ-029 With rst_n=0 at a clock edge: both banks EMPTY; write and read bank pointers 0; count 0; writer in W_FILL.
REQ-030 Output reset values: wr_ready=0 during reset and 1 the first cycle after; pkt_valid=0; pkt_len=0; rd_data=0; rd_last=0; err_oversize=0.
REQ-031 Reset mid-write or mid-read SHALL discard all stored packets; RAM contents need not clear.

Configuration
REQ-032 Macro UDP_PAYLOAD_PAD_EN defined: a packet shorter than 18 bytes SHALL report pkt_len=18 and read bytes beyond its written length as 8'h00, so the frame meets the 64-byte Ethernet minimum.
REQ-033 UDP_PAYLOAD_PAD_EN undefined: pkt_len equals bytes written; no padding logic is present.

Verification
REQ-034 Write 32 bytes 0x00..0x1F with wr_last on 0x1F -> pkt_valid next cycle, pkt_len=32; 32 continuous rd_en -> rd_data 0x00..0x1F, rd_last with 0x1F.
REQ-035 Write three 100-byte packets back-to-back with no reads -> wr_ready=0 after the second; reading packet 1 (rd_last) -> wr_ready=1 next cycle; packets 2, 3 read intact in order.
REQ-036 Write 1473 bytes with MAX_SIZE=1472 -> err_oversize single pulse after wr_last; pkt_valid stays 0; the next 64-byte packet reads correctly.
REQ-037 Write 5 bytes 0xA1..0xA5 -> pkt_len=18 with rd_data A1..A5 then thirteen 0x00 (PAD_EN defined); pkt_len=5 (undefined).
REQ-038 Assert rst_n=0 while byte 40 of 200 is being read -> after reset pkt_valid=0, rd_last=0, wr_ready=1; a fresh 64-byte packet reads correctly.
REQ-039 rd_en toggled 1/0 every cycle over a 64-byte packet -> every byte appears once in order, rd_data holding during gaps.
